cap_sense_scanner: RTL

Time-multiplexed controller for the nine capacitive touch pads. The pads share one drive line (capacitive_sensors_out) and one charge-time counter. The block sequences discharge/charge/measure over pads 0..8 and compares each charge time against a threshold. It publishes an atomic 9-bit touch mask to the skeleton's memory-mapped I/O, where the processor reads it as whack-a-mole hit input.

---
 rtl/cap_sense_scanner.sv | 137 +++++++++++++
 1 files changed

// File: rtl/cap_sense_scanner.sv
// Time-multiplexed capacitive pad scanner: discharge, charge and time each pad in turn,
// then publish a thresholded touch mask atomically at the end of every full sweep.
module cap_sense_scanner #(
  parameter int unsigned NUM_SENSORS      = 9,
  parameter int unsigned CNT_W            = 16,
  parameter int unsigned DISCHARGE_CYCLES = 256,
  parameter int unsigned TIMEOUT          = 4095
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [CNT_W-1:0]       threshold,
  input  logic [NUM_SENSORS-1:0] capacitive_sensors_in,
  output logic                   capacitive_sensors_out,
  output logic [NUM_SENSORS-1:0] touched,
  output logic                   touch_valid,
  output logic [CNT_W-1:0]       last_count,
  output logic [3:0]             last_index,
  output logic                   busy
);

  localparam logic [CNT_W-1:0] DisLast    = CNT_W'(DISCHARGE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT);
  localparam logic [3:0]       IdxLast    = 4'(NUM_SENSORS - 1);

  typedef enum logic [1:0] {StIdle, StDischarge, StCharge, StNext} state_e;

  state_e                 state_q, state_d;
  logic [NUM_SENSORS-1:0] sync1_q, sync2_q;
  logic [3:0]             idx_q, idx_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       thr_q, thr_d;
  logic [NUM_SENSORS-1:0] shadow_q, shadow_d;
  logic [NUM_SENSORS-1:0] merged;
  logic [CNT_W-1:0]       last_count_q, last_count_d;
  logic [3:0]             last_index_q, last_index_d;
  logic [NUM_SENSORS-1:0] touched_q, touched_d;
  logic                   touch_valid_q, touch_valid_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      sync1_q       <= '0;
      sync2_q       <= '0;
      idx_q         <= '0;
      cnt_q         <= '0;
      thr_q         <= '0;
      shadow_q      <= '0;
      last_count_q  <= '0;
      last_index_q  <= '0;
      touched_q     <= '0;
      touch_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync1_q       <= capacitive_sensors_in;
      sync2_q       <= sync1_q;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      thr_q         <= thr_d;
      shadow_q      <= shadow_d;
      last_count_q  <= last_count_d;
      last_index_q  <= last_index_d;
      touched_q     <= touched_d;
      touch_valid_q <= touch_valid_d;
    end
  end

  // One counter serves both the discharge hold and the charge-time measurement.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    thr_d         = thr_q;
    shadow_d      = shadow_q;
    last_count_d  = last_count_q;
    last_index_d  = last_index_q;
    touched_d     = touched_q;
    touch_valid_d = 1'b0;
    merged        = shadow_q;
    merged[idx_q] = (last_count_q >= thr_q);
    unique case (state_q)
      StIdle: begin
        if (enable) begin
          thr_d    = threshold;
          idx_d    = '0;
          shadow_d = '0;
          cnt_d    = '0;
          state_d  = StDischarge;
        end
      end
      StDischarge: begin
        if (cnt_q == DisLast) begin
          cnt_d   = '0;
          state_d = StCharge;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StCharge: begin
        if (sync2_q[idx_q]) begin
          last_count_d = cnt_q;
          state_d      = StNext;
        end else if (cnt_q == TimeoutVal) begin
          last_count_d = TimeoutVal;
          state_d      = StNext;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StNext: begin
        last_index_d = idx_q;
        cnt_d        = '0;
        state_d      = enable ? StDischarge : StIdle;
        if (idx_q == IdxLast) begin
          touched_d     = merged;
          touch_valid_d = 1'b1;
          idx_d         = '0;
          shadow_d      = '0;
          thr_d         = threshold;
        end else begin
          shadow_d = merged;
          idx_d    = idx_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Drive line decoded straight from state so a reset forces it low immediately.
  assign capacitive_sensors_out = (state_q == StCharge);
  assign busy                   = (state_q != StIdle);
  assign touched                = touched_q;
  assign touch_valid            = touch_valid_q;
  assign last_count             = last_count_q;
  assign last_index             = last_index_q;

endmodule
